// File: rtl/adc_conv_sequencer.sv
// Dual-slope ADC conversion sequencer: shorts the integrator cap, integrates the input
// for a fixed time, then times the reference run-down until the comparator trips.
module adc_conv_sequencer #(
    parameter int unsigned RESET_CYCLES = 1000,
    parameter int unsigned RUNUP_CYCLES = 100000,
    parameter int unsigned RUNDOWN_MAX  = 200000,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             comp,
    output logic             m_reset,
    output logic             m_in,
    output logic             m_ref,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] result,
    output logic             overflow
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RESET,
        S_RUNUP,
        S_RUNDOWN
    } state_t;

    // Phase lengths are compared by exact equality, so the counter never needs to wrap.
    localparam logic [CNT_W-1:0] RESET_LAST = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] RUNUP_LAST = CNT_W'(RUNUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] RD_MAX     = CNT_W'(RUNDOWN_MAX);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] result_q, result_d;
    logic             overflow_q, overflow_d;
    logic             done_q, done_d;
    logic             comp_meta_q, comp_s_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        result_d   = result_q;
        overflow_d = overflow_q;
        done_d     = 1'b0;

        if (abort) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_RESET;
                        cnt_d   = '0;
                    end
                end
                S_RESET: begin
                    if (cnt_q == RESET_LAST) begin
                        state_d = S_RUNUP;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_RUNUP: begin
                    if (cnt_q == RUNUP_LAST) begin
                        state_d = S_RUNDOWN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_RUNDOWN: begin
                    // A comparator trip wins over a simultaneous timeout.
                    if (!comp_s_q) begin
                        state_d    = S_IDLE;
                        cnt_d      = '0;
                        result_d   = cnt_q;
                        overflow_d = 1'b0;
                        done_d     = 1'b1;
                    end else if (cnt_q == RD_MAX) begin
                        state_d    = S_IDLE;
                        cnt_d      = '0;
                        result_d   = RD_MAX;
                        overflow_d = 1'b1;
                        done_d     = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            result_q    <= '0;
            overflow_q  <= 1'b0;
            done_q      <= 1'b0;
            comp_meta_q <= 1'b0;
            comp_s_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            overflow_q  <= overflow_d;
            done_q      <= done_d;
            comp_meta_q <= comp;
            comp_s_q    <= comp_meta_q;
        end
    end

    // Switch controls decode straight from the state register, so they never glitch.
    assign m_reset  = (state_q == S_RUNUP) || (state_q == S_RUNDOWN);
    assign m_in     = (state_q == S_RUNUP);
    assign m_ref    = ~m_in;
    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;
    assign result   = result_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_adc_conv_sequencer.sv
// Bench for adc_conv_sequencer: vector table, hand-written corner sequences and random
// conversions checked cycle by cycle against a timeline model of the conversion.
module tb_adc_conv_sequencer;

    localparam int R = 4;
    localparam int U = 10;
    localparam int M = 20;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n, start, abort, comp;
    logic         m_reset, m_in, m_ref, busy, done, overflow;
    logic [W-1:0] result;

    adc_conv_sequencer #(
        .RESET_CYCLES(R),
        .RUNUP_CYCLES(U),
        .RUNDOWN_MAX (M),
        .CNT_W       (W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .abort   (abort),
        .comp    (comp),
        .m_reset (m_reset),
        .m_in    (m_in),
        .m_ref   (m_ref),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    int           n_cmp  = 0;
    int           n_fail = 0;
    logic [W-1:0] m_res  = '0;
    logic         m_ovf  = 1'b0;

    typedef struct {
        int           kdrop;     // rundown k at which comp_s first reads 0 (99 = never)
        int           abort_at;  // cycle abort is driven, -1 = none
        logic [W-1:0] e_res;
        logic         e_ovf;
        int           e_done;
    } vec_t;

    vec_t tbl [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected outputs in cycle c of a conversion whose start was sampled at the end of cycle s.
    task automatic check_cycle(input string tag, input int c, input int s, input bit e_busy,
                               input bit e_done);
        bit e_mr, e_mi;
        int r;
        r    = c - s;
        e_mr = e_busy && (r > R);
        e_mi = e_busy && (r > R) && (r <= R + U);
        check($sformatf("%s outs c%0d {busy,m_reset,m_in,m_ref,done}", tag, c),
              {27'd0, busy, m_reset, m_in, m_ref, done},
              {27'd0, e_busy, e_mr, e_mi, ~e_mi, e_done});
        check($sformatf("%s result c%0d", tag, c), result, m_res);
        check($sformatf("%s overflow c%0d", tag, c), {31'd0, overflow}, {31'd0, m_ovf});
    endtask

    // One conversion started in cycle 0 (caller is just after an edge).
    task automatic run_conv(input string tag, input int kdrop, input int abort_at,
                            output int ndone);
        int  rd0, kend, endc, last;
        bit  ovf, aborted, e_done;
        rd0     = R + U + 1;
        kend    = (kdrop <= M) ? kdrop : M;
        ovf     = (kdrop > M);
        endc    = rd0 + kend;
        aborted = (abort_at >= 0) && (abort_at <= endc);
        last    = aborted ? abort_at : endc;
        ndone   = 0;
        start   = 1'b1;
        comp    = 1'b1;
        abort   = (abort_at == 0);
        for (int c = 1; c <= endc + 3; c++) begin
            step();
            start  = 1'b0;
            comp   = (c >= rd0 + kdrop - 2) ? 1'b0 : 1'b1;
            abort  = (c == abort_at);
            e_done = !aborted && (c == endc + 1);
            if (e_done) begin
                m_res = W'(kend);
                m_ovf = ovf;
            end
            check_cycle(tag, c, 0, (c <= last), e_done);
            ndone += int'(done);
        end
        abort = 1'b0;
    endtask

    initial begin
        int nd, k, a;

        tbl[0]  = '{7, -1, 32'd7, 1'b0, 1};
        tbl[1]  = '{5, 13, 32'd7, 1'b0, 0};   // abort in RUNUP
        tbl[2]  = '{99, -1, 32'd20, 1'b1, 1}; // timeout
        tbl[3]  = '{0, -1, 32'd0, 1'b0, 1};   // trip in first rundown cycle
        tbl[4]  = '{99, 35, 32'd0, 1'b0, 0};  // abort on the timeout cycle
        tbl[5]  = '{20, -1, 32'd20, 1'b0, 1}; // trip and timeout together
        tbl[6]  = '{19, -1, 32'd19, 1'b0, 1};
        tbl[7]  = '{3, 0, 32'd19, 1'b0, 0};   // start and abort together
        tbl[8]  = '{21, -1, 32'd20, 1'b1, 1};
        tbl[9]  = '{4, 1, 32'd20, 1'b1, 0};   // abort in first RESET cycle
        tbl[10] = '{10, 25, 32'd20, 1'b1, 0}; // abort on the trip cycle
        tbl[11] = '{2, -1, 32'd2, 1'b0, 1};

        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        comp  = 1'b0;
        step();
        step();
        check("reset m_reset", {31'd0, m_reset}, 32'd0);
        check("reset m_in", {31'd0, m_in}, 32'd0);
        check("reset m_ref", {31'd0, m_ref}, 32'd1);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset result", result, 32'd0);
        check("reset overflow", {31'd0, overflow}, 32'd0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 12; i++) begin
            run_conv($sformatf("tbl%0d", i), tbl[i].kdrop, tbl[i].abort_at, nd);
            check($sformatf("tbl%0d final result", i), result, tbl[i].e_res);
            check($sformatf("tbl%0d final overflow", i), {31'd0, overflow}, {31'd0, tbl[i].e_ovf});
            check($sformatf("tbl%0d done pulses", i), nd, tbl[i].e_done);
        end

        // rst_n mid-conversion clears the previous result
        start = 1'b1;
        comp  = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            step();
            start = 1'b0;
        end
        check("midreset busy before", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        m_res = '0;
        m_ovf = 1'b0;
        check_cycle("midreset", 21, 21, 1'b0, 1'b0);
        step();

        // start held high: two back-to-back conversions, comp_s trips at k=3 each time
        start = 1'b1;
        comp  = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            bit e_busy, e_done;
            step();
            comp   = ((c >= 16 && c <= 31) || c >= 35) ? 1'b0 : 1'b1;
            start  = (c < 37);
            e_busy = (c <= 18) || (c >= 20 && c <= 37);
            e_done = (c == 19) || (c == 38);
            if (e_done) begin
                m_res = 32'd3;
                m_ovf = 1'b0;
            end
            check_cycle("b2b", c, (c >= 20) ? 19 : 0, e_busy, e_done);
        end
        comp = 1'b1;
        step();

        for (int i = 0; i < 40; i++) begin
            k = int'($urandom_range(0, 25));
            a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 40)) : -1;
            run_conv($sformatf("rnd%0d", i), k, a, nd);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
